// File: rtl/mem_ctrl.sv
// Memory access sequencer: owns MAR/MDR and turns one-cycle read/write requests
// into timed strobes for a synchronous RAM with one cycle of registered read latency.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] MDR_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                err_q, err_d;
  logic                ram_read_q, ram_write_q, busy_q, done_q;
  logic                load_ok;
  logic                unused_bus_hi;

  // Upper bus bits never reach MAR; the RAM only decodes ADDR_W bits.
  assign unused_bus_hi = ^BusMuxOut[DATA_W-1:ADDR_W];

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    load_ok = (state_q == IDLE) || (state_q == DONE);

    // Loads land before the access starts, so a same-cycle request sees them.
    if (load_ok && MARin) mar_d = BusMuxOut[ADDR_W-1:0];
    if (load_ok && MDRin) mdr_d = BusMuxOut;

    case (state_q)
      IDLE: begin
        if (mem_wr) begin
          state_d = WR;
          if (mem_rd) err_d = 1'b1;
        end else if (mem_rd) begin
          state_d = RD_ISSUE;
        end
      end
      WR:       state_d = DONE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = DONE;
        mdr_d   = MDataIn;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (mem_rd || mem_wr)) err_d = 1'b1;
  end

  // Strobes are registered copies of the next-state decode, so they track state_q exactly.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      err_q       <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      err_q       <= err_d;
      ram_read_q  <= (state_d == RD_ISSUE);
      ram_write_q <= (state_d == WR);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = mar_q;
  assign ram_wdata = mdr_q;
  assign MDR_out   = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
